sum8_accum_amisha: RTL and testbench
====================================

Name: sum8_accum_amisha

Overview:
- Downstream consumer of the 8-bit adder stage. Takes {carry, sum} results (c8_amisha, sum8_amisha) under a valid/ready handshake and accumulates a batch of N_SAMPLES results into a wide register.
- Reports batch completion with a one-cycle done pulse and a sticky overflow flag.
- Lets the combinational adder be exercised as a running-sum datapath.

Parameters:
- N_SAMPLES, 4, results per batch; legal range 1..15.
- ACC_W, 12, accumulator width in bits; minimum 9.

Ports:
- clk_amisha  input  1  sole clock; all state updates on rising edge.
- rst_n_amisha  input  1  asynchronous, active-low reset.
- start_amisha  input  1  begin a new batch; sampled only in IDLE.
- in_valid_amisha  input  1  sum8_amisha/c8_amisha hold a valid adder result.
- sum8_amisha  input  8  adder sum.
- c8_amisha  input  1  adder carry-out.
- in_ready_amisha  output  1  block accepts a result this cycle.
- acc_amisha  output  ACC_W  running/final accumulated value.
- count_amisha  output  4  results accepted in current batch.
- done_amisha  output  1  one-cycle pulse; batch complete.
- overflow_amisha  output  1  sticky; accumulator wrapped during current batch.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: state=IDLE, acc_amisha=0, count_amisha=0, done_amisha=0, overflow_amisha=0, in_ready_amisha=0.
- Reset asserted mid-batch aborts immediately to these values. No partial result is retained.
- Operand: 9-bit {c8_amisha, sum8_amisha}, zero-extended to ACC_W (range 0..511).
- States: IDLE, ACCUM, DONE. in_ready_amisha is combinational, equal to (state==ACCUM).
- IDLE:
  - in_valid_amisha is ignored.
  - start_amisha=1 -> next state ACCUM. Same edge clears acc_amisha, count_amisha and overflow_amisha to 0.
  - acc_amisha otherwise holds the previous batch result.
- ACCUM:
  - Accept when in_valid_amisha && in_ready_amisha. No latency: the operand is added into acc_amisha on that same edge and count_amisha increments.
  - No accept -> acc_amisha and count_amisha hold. Gaps of any length are legal.
  - start_amisha is ignored.
  - Accept with count_amisha==N_SAMPLES-1 -> count becomes N_SAMPLES and next state is DONE.
- Accumulator arithmetic is modulo 2^ACC_W. If the (ACC_W+1)-bit sum has its MSB set, acc_amisha takes the low ACC_W bits and overflow_amisha sets to 1. It stays 1 until the next start or reset.
- DONE:
  - done_amisha=1 for exactly this one cycle (registered, asserted the cycle after the final accept).
  - in_ready_amisha=0. acc_amisha, count_amisha and overflow_amisha hold.
  - Unconditional return to IDLE next edge. start_amisha during DONE is ignored.
- Minimum batch time: 1 (start) + N_SAMPLES (accepts) + 1 (DONE) cycles.
- N_SAMPLES=1: the first accept goes straight to DONE.
- Back-to-back batches: start may be asserted in the IDLE cycle immediately after DONE.

Test Plan:
- Reset then idle: hold rst_n_amisha=0 for 3 cycles, release, keep start=0, toggle in_valid 10 cycles.
  -> acc=0, count=0, ready=0, done never asserts.
- Nominal batch (N=4, ACC_W=12): start, then feed adder results back-to-back, each as {c8,sum8}:
  - 0x0B3 (0xB3+0x00)
  - 0x0F0 (0x4C+0xA4)
  - 0x0E3 (0xB8+0x2B)
  - 0x186 (0xC3+0xC3)
  - Expected: acc=0x40C (1036), count=4, overflow=0. done pulses exactly one cycle, the cycle after the 4th accept.
- Valid gaps: same four operands with in_valid deasserted 2 cycles between each.
  -> same final acc=0x40C. acc and count unchanged during gaps.
- Overflow (override ACC_W=10, N=4): four operands of 0x1FF (511).
  -> acc=0x3FC (2044 mod 1024 = 1020), overflow=1 from the 3rd accept onward.
  -> Next start clears overflow to 0.
- Reset mid-batch: assert rst_n_amisha low after 2 accepts.
  -> acc, count, overflow and ready drop to 0 asynchronously, before the next clock edge. After release, state is IDLE and no done pulse occurs.
- Ignored start: pulse start during ACCUM (after 1 accept) and during DONE.
  -> count continues undisturbed, acc not cleared, exactly one done pulse.

Source files
------------

// File: rtl/sum8_accum_amisha.sv
// Batch accumulator for {carry, sum} results of the 8-bit adder stage.
// Collects N_SAMPLES results under valid/ready, then pulses done for one cycle.
module sum8_accum_amisha #(
    parameter int N_SAMPLES = 4,
    parameter int ACC_W     = 12
) (
    input  logic             clk_amisha,
    input  logic             rst_n_amisha,
    input  logic             start_amisha,
    input  logic             in_valid_amisha,
    input  logic [7:0]       sum8_amisha,
    input  logic             c8_amisha,
    output logic             in_ready_amisha,
    output logic [ACC_W-1:0] acc_amisha,
    output logic [3:0]       count_amisha,
    output logic             done_amisha,
    output logic             overflow_amisha
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DONE
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(N_SAMPLES - 1);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [3:0]       count_q, count_d;
    logic             done_q, done_d;
    logic             overflow_q, overflow_d;

    logic             accept;
    logic [ACC_W:0]   sum_wide;

    assign in_ready_amisha = (state_q == ST_ACCUM);
    assign accept          = in_valid_amisha && in_ready_amisha;

    // One spare bit above the accumulator captures the wrap for the overflow flag.
    assign sum_wide = {1'b0, acc_q} + {{(ACC_W - 8){1'b0}}, c8_amisha, sum8_amisha};

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_amisha) begin
                    state_d    = ST_ACCUM;
                    acc_d      = '0;
                    count_d    = '0;
                    overflow_d = 1'b0;
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    acc_d   = sum_wide[ACC_W-1:0];
                    count_d = count_q + 4'd1;
                    if (sum_wide[ACC_W]) begin
                        overflow_d = 1'b1;
                    end
                    if (count_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
        if (!rst_n_amisha) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    assign acc_amisha      = acc_q;
    assign count_amisha    = count_q;
    assign done_amisha     = done_q;
    assign overflow_amisha = overflow_q;

endmodule

// File: tb/tb_sum8_accum_amisha.sv
// Directed bench for sum8_accum_amisha: nominal, gapped, overflow, reset and ignored-start cases.
// Three instances share stimulus: default (N=4, W=12), narrow (N=4, W=10), single-sample (N=1).
module tb_sum8_accum_amisha;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        valid;
    logic [7:0]  sum8;
    logic        c8;

    logic        rdy_a, done_a, ovf_a;
    logic [11:0] acc_a;
    logic [3:0]  cnt_a;

    logic        rdy_b, done_b, ovf_b;
    logic [9:0]  acc_b;
    logic [3:0]  cnt_b;

    logic        rdy_c, done_c, ovf_c;
    logic [11:0] acc_c;
    logic [3:0]  cnt_c;

    int vectors    = 0;
    int miscompares = 0;

    logic [8:0]  ops   [4] = '{9'h0B3, 9'h0F0, 9'h0E3, 9'h186};
    logic [11:0] run_a [4] = '{12'h0B3, 12'h1A3, 12'h286, 12'h40C};
    logic [9:0]  run_b [4] = '{10'h1FF, 10'h3FE, 10'h1FD, 10'h3FC};

    sum8_accum_amisha #(.N_SAMPLES(4), .ACC_W(12)) dut_a (
        .clk_amisha(clk), .rst_n_amisha(rst_n), .start_amisha(start),
        .in_valid_amisha(valid), .sum8_amisha(sum8), .c8_amisha(c8),
        .in_ready_amisha(rdy_a), .acc_amisha(acc_a), .count_amisha(cnt_a),
        .done_amisha(done_a), .overflow_amisha(ovf_a)
    );

    sum8_accum_amisha #(.N_SAMPLES(4), .ACC_W(10)) dut_b (
        .clk_amisha(clk), .rst_n_amisha(rst_n), .start_amisha(start),
        .in_valid_amisha(valid), .sum8_amisha(sum8), .c8_amisha(c8),
        .in_ready_amisha(rdy_b), .acc_amisha(acc_b), .count_amisha(cnt_b),
        .done_amisha(done_b), .overflow_amisha(ovf_b)
    );

    sum8_accum_amisha #(.N_SAMPLES(1), .ACC_W(12)) dut_c (
        .clk_amisha(clk), .rst_n_amisha(rst_n), .start_amisha(start),
        .in_valid_amisha(valid), .sum8_amisha(sum8), .c8_amisha(c8),
        .in_ready_amisha(rdy_c), .acc_amisha(acc_c), .count_amisha(cnt_c),
        .done_amisha(done_c), .overflow_amisha(ovf_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [11:0] acc, input int cnt,
                         input logic rdy, input logic dn, input logic ov);
        check({tag, ".acc_a"},   32'(acc_a),  32'(acc));
        check({tag, ".cnt_a"},   32'(cnt_a),  32'(cnt));
        check({tag, ".rdy_a"},   32'(rdy_a),  32'(rdy));
        check({tag, ".done_a"},  32'(done_a), 32'(dn));
        check({tag, ".ovf_a"},   32'(ovf_a),  32'(ov));
    endtask

    task automatic chk_b(input string tag, input logic [9:0] acc, input int cnt,
                         input logic rdy, input logic dn, input logic ov);
        check({tag, ".acc_b"},   32'(acc_b),  32'(acc));
        check({tag, ".cnt_b"},   32'(cnt_b),  32'(cnt));
        check({tag, ".rdy_b"},   32'(rdy_b),  32'(rdy));
        check({tag, ".done_b"},  32'(done_b), 32'(dn));
        check({tag, ".ovf_b"},   32'(ovf_b),  32'(ov));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [8:0] op);
        {c8, sum8} = op;
        valid      = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        valid = 1'b0;
        sum8  = 8'h00;
        c8    = 1'b0;

        // Reset held for 3 cycles, then idle with toggling valid.
        repeat (3) @(posedge clk);
        #1;
        chk_a("in_reset", 12'h000, 0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(9'h155);
            valid = i[0];
            tick();
            chk_a("idle", 12'h000, 0, 1'b0, 1'b0, 1'b0);
        end

        // Nominal back-to-back batch.
        valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_a("nom_start", 12'h000, 0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(ops[i]);
            tick();
            if (i < 3) chk_a("nom_acc", run_a[i], i + 1, 1'b1, 1'b0, 1'b0);
            else       chk_a("nom_done", 12'h40C, 4, 1'b0, 1'b1, 1'b0);
            if (i == 0) begin
                check("n1_done_c", 32'(done_c), 32'h1);
                check("n1_acc_c",  32'(acc_c),  32'h0B3);
                check("n1_cnt_c",  32'(cnt_c),  32'h1);
            end
        end
        valid = 1'b0;
        tick();
        chk_a("nom_idle", 12'h40C, 4, 1'b0, 1'b0, 1'b0);
        check("n1_hold_acc_c", 32'(acc_c), 32'h0B3);
        check("n1_hold_done_c", 32'(done_c), 32'h0);

        // Same operands with two idle-valid cycles between accepts.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_a("gap_start", 12'h000, 0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(ops[i]);
            tick();
            if (i < 3) begin
                chk_a("gap_acc", run_a[i], i + 1, 1'b1, 1'b0, 1'b0);
                valid = 1'b0;
                sum8  = 8'hFF;
                c8    = 1'b1;
                repeat (2) begin
                    tick();
                    chk_a("gap_hold", run_a[i], i + 1, 1'b1, 1'b0, 1'b0);
                end
            end else begin
                chk_a("gap_done", 12'h40C, 4, 1'b0, 1'b1, 1'b0);
            end
        end
        valid = 1'b0;
        tick();
        chk_a("gap_idle", 12'h40C, 4, 1'b0, 1'b0, 1'b0);

        // Overflow on the 10-bit instance: four 0x1FF operands.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_b("ovf_start", 10'h000, 0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(9'h1FF);
            tick();
            chk_b("ovf_acc", run_b[i], i + 1, (i < 3), (i == 3), (i >= 2));
        end
        check("ovf_wide_acc_a", 32'(acc_a), 32'h7FC);
        check("ovf_wide_ovf_a", 32'(ovf_a), 32'h0);
        valid = 1'b0;
        tick();
        chk_b("ovf_sticky", 10'h3FC, 4, 1'b0, 1'b0, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_b("ovf_clear", 10'h000, 0, 1'b1, 1'b0, 1'b0);

        // Reset mid-batch after two accepts; outputs drop before the next edge.
        drive(9'h010);
        tick();
        chk_a("rst_acc1", 12'h010, 1, 1'b1, 1'b0, 1'b0);
        drive(9'h020);
        tick();
        chk_a("rst_acc2", 12'h030, 2, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        chk_a("rst_async", 12'h000, 0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_a("rst_after", 12'h000, 0, 1'b0, 1'b0, 1'b0);
        end

        // Start pulses during ACCUM and DONE are ignored.
        valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_a("ign_start", 12'h000, 0, 1'b1, 1'b0, 1'b0);
        drive(ops[0]);
        tick();
        chk_a("ign_acc0", 12'h0B3, 1, 1'b1, 1'b0, 1'b0);
        valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_a("ign_accum_start", 12'h0B3, 1, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 4; i++) begin
            drive(ops[i]);
            tick();
            if (i < 3) chk_a("ign_acc", run_a[i], i + 1, 1'b1, 1'b0, 1'b0);
            else       chk_a("ign_done", 12'h40C, 4, 1'b0, 1'b1, 1'b0);
        end
        valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_a("ign_done_start", 12'h40C, 4, 1'b0, 1'b0, 1'b0);
        tick();
        chk_a("ign_idle", 12'h40C, 4, 1'b0, 1'b0, 1'b0);

        // Fresh batch starts from IDLE.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_a("restart", 12'h000, 0, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
